// File: rtl/gci_irq_arbiter.sv
// gci_irq_arbiter: priority interrupt arbiter between four GCI nodes and one CPU.
// Optional build macro GCI_IRQ_ROUNDROBIN_EN: equal-priority ties rotate from
// (last granted node + 1); without it ties go to the lowest node index.
`timescale 1ns/1ps
module gci_irq_arbiter #(
    parameter logic [7:0] ACK_TIMEOUT = 8'hFF
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic [3:0]  iNODE_VALID,
    input  logic [31:0] iNODE_PRIORITY,
    input  logic [3:0]  iNODE_IRQ_REQ,
    output logic [3:0]  oNODE_IRQ_ACK,
    output logic [3:0]  oNODE_IRQ_BUSY,
    input  logic [3:0]  iIRQ_MASK,
    output logic        oIRQ_REQ,
    output logic [1:0]  oIRQ_NUM,
    input  logic        iIRQ_ACK,
    input  logic        iIRQ_BUSY,
    output logic        oIRQ_TIMEOUT
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK, S_DROP} state_t;
    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        timeout_q, timeout_d;
    logic [3:0]  eligible;
    logic        found;
    logic [1:0]  winner, idx, ptr;
    logic [7:0]  best;
    logic        node_ack;

    assign eligible = iNODE_IRQ_REQ & iNODE_VALID & iIRQ_MASK;
    assign node_ack = (state_q == S_ACK) && !iIRQ_BUSY;

`ifdef GCI_IRQ_ROUNDROBIN_EN
    logic [1:0] ptr_q, ptr_d;
    assign ptr   = ptr_q;
    assign ptr_d = node_ack ? grant_q + 2'd1 : ptr_q;
    // Rotating tie-break start, advanced past the node that was just acknowledged
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) ptr_q <= 2'd0;
        else          ptr_q <= ptr_d;
    end
`else
    assign ptr = 2'd0;
`endif

    // Highest priority eligible node; strict compare keeps the first hit in search order on ties
    always_comb begin
        winner = ptr;
        best   = 8'h00;
        found  = 1'b0;
        idx    = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (eligible[idx] && (!found || iNODE_PRIORITY[8*idx +: 8] > best)) begin
                winner = idx;
                best   = iNODE_PRIORITY[8*idx +: 8];
                found  = 1'b1;
            end
        end
    end

    // Next state: grant in IDLE, wait for CPU ack in REQ (drop beats ack beats timeout)
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: if (found && !iIRQ_BUSY) begin
                state_d = S_REQ;
                grant_d = winner;
                cnt_d   = 8'h00;
            end
            S_REQ: begin
                if (!iNODE_VALID[grant_q] || !iIRQ_MASK[grant_q])
                    state_d = S_IDLE;
                else if (iIRQ_ACK)
                    state_d = S_ACK;
                else if (ACK_TIMEOUT != 8'h00 && cnt_q == ACK_TIMEOUT - 8'd1) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end else
                    cnt_d = cnt_q + 8'd1;
            end
            S_ACK:  if (!iIRQ_BUSY) state_d = S_DROP;
            S_DROP: if (!iNODE_IRQ_REQ[grant_q] || !iNODE_VALID[grant_q]) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, grant, ack-wait counter and timeout pulse registers
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q   <= S_IDLE;
            grant_q   <= 2'd0;
            cnt_q     <= 8'h00;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign oIRQ_REQ       = (state_q == S_REQ);
    assign oIRQ_NUM       = grant_q;
    assign oIRQ_TIMEOUT   = timeout_q;
    assign oNODE_IRQ_ACK  = node_ack ? 4'b0001 << grant_q : 4'h0;
    assign oNODE_IRQ_BUSY = {4{iIRQ_BUSY}};
endmodule
